piso_in_filter: RTL and testbench

//  Downstream consumer of the 74AHC595/165 serial chain driver. It samples the word read

---
 rtl/piso_in_filter.sv | 108 ++++++++++
 tb/tb_piso_in_filter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/piso_in_filter.sv
// rtl/piso_in_filter.sv - per-bit debounce, edge pulses and sticky latches for the serial input chain
module piso_in_filter #(
    parameter int               WIDTH    = 16,
    parameter int               FILT_LEN = 4,
    parameter logic [WIDTH-1:0] INIT     = '0
) (
    input  logic             clk,
    input  logic             sclr_n,
    input  logic             busy,
    input  logic [WIDTH-1:0] shift,
    input  logic [WIDTH-1:0] latch_clr,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] sticky,
    output logic             changed,
    output logic             valid,
    output logic             ready
);

    localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(FILT_LEN - 1);

    localparam logic [0:0] ST_PRIME = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [0:0]       state;
    logic             busy_d;
    logic             smp;
    logic [CW-1:0]    cnt      [WIDTH];
    logic [CW-1:0]    cnt_n    [WIDTH];
    logic [WIDTH-1:0] data_n;
    logic [WIDTH-1:0] rise_n;
    logic [WIDTH-1:0] fall_n;
    logic [WIDTH-1:0] sticky_n;

    // The serializer may reload shift right after busy falls, so the word is taken in the strobe cycle
    assign smp = busy_d & ~busy;

    // Next-state debounce: first sample primes, later samples must differ FILT_LEN times in a row
    always_comb begin
        data_n   = data_out;
        rise_n   = '0;
        fall_n   = '0;
        sticky_n = sticky;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_n[i] = cnt[i];
        end
        if (smp) begin
            if (state == ST_PRIME) begin
                data_n = shift;
                for (int i = 0; i < WIDTH; i++) begin
                    cnt_n[i] = '0;
                end
            end else begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (shift[i] == data_out[i]) begin
                        cnt_n[i] = '0;
                    end else if (cnt[i] == CNT_MAX) begin
                        data_n[i] = shift[i];
                        cnt_n[i]  = '0;
                        rise_n[i] = shift[i];
                        fall_n[i] = ~shift[i];
                    end else begin
                        cnt_n[i] = cnt[i] + CW'(1);
                    end
                end
            end
        end
        if (state == ST_RUN) begin
            sticky_n = (sticky & ~latch_clr) | rise_n | fall_n;
        end
    end

    // Register filtered word, counters, pulses and the prime/run state
    always_ff @(posedge clk) begin
        if (!sclr_n) begin
            state    <= ST_PRIME;
            busy_d   <= 1'b0;
            data_out <= INIT;
            rise     <= '0;
            fall     <= '0;
            sticky   <= '0;
            changed  <= 1'b0;
            valid    <= 1'b0;
            ready    <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            busy_d   <= busy;
            data_out <= data_n;
            rise     <= rise_n;
            fall     <= fall_n;
            sticky   <= sticky_n;
            changed  <= |(rise_n | fall_n);
            valid    <= smp;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_n[i];
            end
            if (smp) begin
                state <= ST_RUN;
                ready <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_piso_in_filter.sv
// tb/tb_piso_in_filter.sv - self-checking bench for piso_in_filter
module tb_piso_in_filter;

    localparam int W    = 16;
    localparam int FILT = 4;

    logic         clk = 1'b0;
    logic         sclr_n = 1'b0;
    logic         busy = 1'b0;
    logic [W-1:0] shift = '0;
    logic [W-1:0] latch_clr = '0;
    logic [W-1:0] data_out, rise, fall, sticky;
    logic         changed, valid, ready;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic [W-1:0] m_data;
    logic [W-1:0] m_sticky;
    logic         m_primed;
    int           m_run [W];
    logic [W-1:0] e_rise, e_fall;

    piso_in_filter #(.WIDTH(W), .FILT_LEN(FILT), .INIT('0)) dut (
        .clk(clk), .sclr_n(sclr_n), .busy(busy), .shift(shift), .latch_clr(latch_clr),
        .data_out(data_out), .rise(rise), .fall(fall), .sticky(sticky),
        .changed(changed), .valid(valid), .ready(ready)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_data = '0; m_sticky = '0; m_primed = 1'b0;
        for (int i = 0; i < W; i++) m_run[i] = 0;
    endtask

    // one processed sample: a bit changes only after FILT consecutive differing readings
    task automatic model_step(input logic [W-1:0] w, input logic [W-1:0] clr);
        e_rise = '0; e_fall = '0;
        if (!m_primed) begin
            m_data = w; m_primed = 1'b1;
            for (int i = 0; i < W; i++) m_run[i] = 0;
        end else begin
            for (int i = 0; i < W; i++) begin
                if (w[i] != m_data[i]) begin
                    m_run[i]++;
                    if (m_run[i] >= FILT) begin
                        if (w[i]) e_rise[i] = 1'b1; else e_fall[i] = 1'b1;
                        m_data[i] = w[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_sticky = (m_sticky & ~clr) | e_rise | e_fall;
        end
    endtask

    task automatic do_reset();
        sclr_n = 1'b0;
        @(posedge clk); #1;
        sclr_n = 1'b1;
        model_reset();
    endtask

    // drives busy 1 then 0 with the word, then compares everything one clk later
    task automatic sample(input logic [W-1:0] w, input logic [W-1:0] clr, input string tag);
        busy = 1'b1;
        @(posedge clk); #1;
        busy = 1'b0; shift = w; latch_clr = clr;
        model_step(w, clr);
        @(posedge clk); #1;
        latch_clr = '0;
        shift = W'($urandom);
        n_tests++;
        if (data_out !== m_data || rise !== e_rise || fall !== e_fall || sticky !== m_sticky ||
            changed !== |(e_rise | e_fall) || valid !== 1'b1 || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: got data=%h rise=%h fall=%h sticky=%h chg=%b val=%b rdy=%b, want data=%h rise=%h fall=%h sticky=%h chg=%b val=1 rdy=1",
                     tag, data_out, rise, fall, sticky, changed, valid, ready,
                     m_data, e_rise, e_fall, m_sticky, |(e_rise | e_fall));
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (data_out !== '0 || rise !== '0 || fall !== '0 || sticky !== '0 ||
            changed !== 1'b0 || valid !== 1'b0 || ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: data=%h rise=%h fall=%h sticky=%h chg=%b val=%b rdy=%b, want all 0",
                     data_out, rise, fall, sticky, changed, valid, ready);
        end
    endtask

    task automatic test_prime();
        sample(16'hA5A5, '0, "prime_a5a5");
        @(posedge clk); #1;
        n_tests++;
        if (valid !== 1'b0 || changed !== 1'b0) begin
            n_fail++;
            $display("FAIL prime_pulse_end: valid=%b changed=%b, want 0 0", valid, changed);
        end
    endtask

    task automatic test_filter_reject();
        do_reset();
        sample(16'h0001, '0, "rej_prime");
        for (int k = 0; k < 3; k++) sample(16'h0000, '0, "rej_diff");
        sample(16'h0001, '0, "rej_back");
        n_tests++;
        if (data_out !== 16'h0001) begin
            n_fail++;
            $display("FAIL rej_hold: data=%h want 0001", data_out);
        end
    endtask

    task automatic test_filter_accept();
        do_reset();
        sample(16'h0001, '0, "acc_prime");
        for (int k = 0; k < 4; k++) sample(16'h0000, '0, "acc_diff");
        n_tests++;
        if (fall !== 16'h0001 || changed !== 1'b1 || sticky !== 16'h0001 || data_out !== 16'h0000) begin
            n_fail++;
            $display("FAIL acc_fall: data=%h fall=%h chg=%b sticky=%h want 0000 0001 1 0001",
                     data_out, fall, changed, sticky);
        end
        @(posedge clk); #1;
        n_tests++;
        if (fall !== '0 || changed !== 1'b0 || sticky !== 16'h0001) begin
            n_fail++;
            $display("FAIL acc_pulse_end: fall=%h chg=%b sticky=%h want 0000 0 0001", fall, changed, sticky);
        end
    endtask

    task automatic test_sticky_clr();
        for (int k = 0; k < 4; k++) sample(16'h0001, '0, "stk_rise");
        for (int k = 0; k < 3; k++) sample(16'h0000, '0, "stk_diff");
        sample(16'h0000, 16'h0001, "stk_set_wins");
        n_tests++;
        if (sticky !== 16'h0001 || fall !== 16'h0001) begin
            n_fail++;
            $display("FAIL stk_set_wins: sticky=%h fall=%h want 0001 0001", sticky, fall);
        end
        latch_clr = 16'h0001;
        @(posedge clk); #1;
        latch_clr = '0;
        m_sticky = m_sticky & ~16'h0001;
        n_tests++;
        if (sticky !== 16'h0000) begin
            n_fail++;
            $display("FAIL stk_clear: sticky=%h want 0000", sticky);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        sample(16'h0000, '0, "mid_prime");
        sample(16'hFFFF, '0, "mid_diff1");
        sample(16'hFFFF, '0, "mid_diff2");
        do_reset();
        n_tests++;
        if (data_out !== 16'h0000 || ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: data=%h ready=%b want 0000 0", data_out, ready);
        end
        sample(16'hFFFF, '0, "mid_reprime");
    endtask

    task automatic test_idle();
        int pulses;
        pulses = 0;
        busy = 1'b0;
        for (int k = 0; k < 100; k++) begin @(posedge clk); #1; if (valid) pulses++; end
        busy = 1'b1;
        for (int k = 0; k < 100; k++) begin @(posedge clk); #1; if (valid) pulses++; end
        n_tests++;
        if (pulses !== 0) begin
            n_fail++;
            $display("FAIL idle_no_valid: pulses=%0d want 0", pulses);
        end
        busy = 1'b0; shift = m_data;
        model_step(m_data, '0);
        pulses = 0;
        for (int k = 0; k < 6; k++) begin @(posedge clk); #1; if (valid) pulses++; end
        n_tests++;
        if (pulses !== 1) begin
            n_fail++;
            $display("FAIL idle_one_valid: pulses=%0d want 1", pulses);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] tgt, w, clr, noise;
        int gap, stray;
        stray = 0;
        tgt = W'($urandom);
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 5) == 0) tgt = tgt ^ W'($urandom);
            noise = ($urandom_range(0, 3) == 0) ? (W'(1) << $urandom_range(0, W - 1)) : '0;
            w = tgt ^ noise;
            clr = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
                if (valid || changed || rise != '0 || fall != '0) stray++;
            end
            sample(w, clr, "random");
        end
        n_tests++;
        if (stray !== 0) begin
            n_fail++;
            $display("FAIL random_idle_pulses: count=%0d want 0", stray);
        end
    endtask

    initial begin
        model_reset();
        @(posedge clk); #1;
        test_reset();
        test_prime();
        test_filter_reject();
        test_filter_accept();
        test_sticky_clr();
        test_reset_mid();
        test_idle();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
